// File: rtl/rotation_column_timer.sv
// Rotor period measurement and per-column pulse generation.
// One turn is split into 2^SLICES_LOG2 slices of 8 columns each.
module rotation_column_timer #(
  parameter int SLICES_LOG2       = 7,
  parameter int PERIOD_BITS       = 24,
  parameter int MIN_COLUMN_CYCLES = 16
) (
  input  logic                   clk_33,
  input  logic                   rst,
  input  logic                   hall_sync,
  output logic                   column_ready,
  output logic [2:0]             column_idx,
  output logic [SLICES_LOG2-1:0] slice_idx,
  output logic                   slice_start,
  output logic                   period_valid,
  output logic [PERIOD_BITS-1:0] period
);

  localparam int PW    = PERIOD_BITS;
  localparam int XW    = SLICES_LOG2 + 3;
  localparam int SHIFT = SLICES_LOG2 + 3;

  localparam logic [PW-1:0] SAT   = '1;
  localparam logic [PW-1:0] ONE   = PW'(1);
  localparam logic [PW-1:0] MIN_I = PW'(MIN_COLUMN_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic          hall_q;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic [PW-1:0] period_q, period_d;
  logic          pval_q, pval_d;
  logic [PW-1:0] intv_q, intv_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [XW-1:0] pos_q, pos_d;
  logic          ready_q, ready_d;
  logic          sstart_q, sstart_d;

  logic          hall_rise;
  logic          sat;
  logic [PW-1:0] raw;
  logic [PW-1:0] new_intv;
  logic [XW-1:0] pos_nx;

  always_comb begin
    hall_rise = hall_sync & ~hall_q;
    sat       = (cnt_q == SAT);
    raw       = cnt_q >> SHIFT;
    new_intv  = (raw < MIN_I) ? MIN_I : raw;
    pos_nx    = pos_q + XW'(1);

    cnt_d    = sat ? cnt_q : cnt_q + ONE;
    seen_d   = seen_q;
    period_d = period_q;
    pval_d   = pval_q;
    intv_d   = intv_q;
    timer_d  = timer_q;
    pos_d    = pos_q;
    state_d  = state_q;
    ready_d  = 1'b0;
    sstart_d = 1'b0;

    if (hall_rise) begin
      // The edge cycle is cycle 1 of the new turn.
      cnt_d  = ONE;
      seen_d = 1'b1;
      if (seen_q && !sat) begin
        period_d = cnt_q;
        pval_d   = 1'b1;
        intv_d   = new_intv;
        timer_d  = new_intv - ONE;
        pos_d    = '0;
        ready_d  = 1'b1;
        sstart_d = 1'b1;
        state_d  = RUN;
      end else begin
        pval_d  = 1'b0;
        state_d = IDLE;
      end
    end else if (pval_q && sat) begin
      pval_d  = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (timer_q == '0) begin
            timer_d  = intv_q - ONE;
            pos_d    = pos_nx;
            ready_d  = 1'b1;
            sstart_d = (pos_nx[2:0] == 3'd0);
            // Last column of the turn: wait for the next edge.
            if (&pos_nx) state_d = HOLD;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_33) begin
    if (rst) begin
      state_q  <= IDLE;
      hall_q   <= 1'b0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      period_q <= '0;
      pval_q   <= 1'b0;
      intv_q   <= '0;
      timer_q  <= '0;
      pos_q    <= '0;
      ready_q  <= 1'b0;
      sstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hall_q   <= hall_sync;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      period_q <= period_d;
      pval_q   <= pval_d;
      intv_q   <= intv_d;
      timer_q  <= timer_d;
      pos_q    <= pos_d;
      ready_q  <= ready_d;
      sstart_q <= sstart_d;
    end
  end

  assign column_ready = ready_q;
  assign column_idx   = pos_q[2:0];
  assign slice_idx    = pos_q[XW-1:3];
  assign slice_start  = sstart_q;
  assign period_valid = pval_q;
  assign period       = period_q;

endmodule

// File: doc/rotation_column_timer.md
Name: rotation_column_timer

Overview:
- Upstream timing source for the LED column multiplexer.
- Measures the rotor period from the once-per-turn hall sync, then divides each turn into 2^SLICES_LOG2 angular slices of 8 columns each.
- Emits one single-cycle column_ready pulse per column slot, plus slice and column indices, so the display advances in lock-step with rotation.
- Stops all pulses when rotation is lost or unmeasured.

Parameters:
- SLICES_LOG2, 7, log2 of slices per revolution (128 slices).
- PERIOD_BITS, 24, width of the revolution period counter in clk_33 cycles.
- MIN_COLUMN_CYCLES, 16, lower clamp on the column interval; must exceed the mux column display time + 1.

Ports:
- clk_33  in  1  system clock, 33 MHz.
- rst  in  1  reset, synchronous, active-high.
- hall_sync  in  1  hall sensor level, already synchronised to clk_33; rising edge = angle 0.
- column_ready  out  1  one-cycle pulse: start displaying column column_idx.
- column_idx  out  3  column number for the current pulse, 0..7.
- slice_idx  out  SLICES_LOG2  current angular slice.
- slice_start  out  1  one-cycle pulse coincident with column_ready when column_idx==0.
- period_valid  out  1  high while a valid period measurement is held.
- period  out  PERIOD_BITS  last measured revolution period in cycles.

Behaviour:
- Reset (rst high at a clock edge): all outputs 0; edge detector history 0; period counter 0; seen_edge 0; interval 0; timer 0; done 0. Reset mid-revolution discards the measurement.
- Edge detect: hall_rise = hall_sync & ~hall_q, where hall_q is the registered hall_sync.
- Period counter:
  - Increments every cycle and saturates at all-ones.
  - On hall_rise, cleared to 1 (the edge cycle counts as cycle 1 of the new turn).
- On hall_rise:
  - If seen_edge==1 and the counter is not saturated: period <= counter; period_valid <= 1.
  - Otherwise: period_valid <= 0.
  - seen_edge <= 1.
- Saturation loss: if the counter reaches all-ones while period_valid==1, period_valid <= 0 the next cycle (motor stopped). Pulses cease.
- Interval:
  - raw = period >> (SLICES_LOG2+3), computed from the newly latched period.
  - interval = max(raw, MIN_COLUMN_CYCLES).
- States:
  - IDLE: no pulses. On hall_rise that yields period_valid==1, go to RUN.
  - RUN: column_ready fires on the cycle after hall_rise with column_idx=0, slice_idx=0, slice_start=1. The down-timer is loaded with interval-1.
    - Each cycle the timer decrements. At 0, the next column pulse fires and the timer reloads with interval-1, so pulses are spaced exactly interval cycles apart.
    - Index advance per pulse: column_idx+1; on 7->0, slice_idx+1.
  - HOLD: entered after the pulse for slice 2^SLICES_LOG2-1, column 7, if no new edge has arrived (rotor slowing). No pulses until the next hall_rise. Indices hold at their last values.
- Any hall_rise in RUN or HOLD:
  - Resynchronises: the timer and indices restart; the first pulse fires on the next cycle with idx 0/0.
  - Remaining columns of the old turn are dropped.
  - If a timer expiry coincides with hall_rise, the edge wins; only one pulse is produced.
- Loss of period_valid in any state: go to IDLE immediately; column_ready is not asserted that cycle.
- column_ready never asserts on two consecutive cycles: guaranteed by MIN_COLUMN_CYCLES >= 2.
- column_idx, slice_idx and slice_start are registered and change only on the cycle column_ready is asserted; slice_start is 0 otherwise.

Test Plan:
- Reset, then hall edges every 102400 cycles -> first edge gives no pulses and period_valid=0. Second edge: period=102400, period_valid=1, pulse one cycle later with idx 0/0 and slice_start=1, then pulses every 100 cycles. slice_idx reaches 127 and column_idx 7 on pulse 1024.
- Period 8192 (raw interval 8) -> interval clamped to 16. After pulse 512 (slice 63, column 7) the early edge resyncs to idx 0/0 with no double pulse.
- Period 204800, then next turn 230000 -> 1024 pulses at interval 200 in the second turn, then HOLD with no pulses until the edge at 230000, then resync.
- hall_sync held low after the valid edge until the counter saturates (PERIOD_BITS=12 variant) -> period_valid falls, column_ready stays 0, state IDLE. The next two edges restore operation.
- Assert rst for one cycle mid-RUN (slice 40) -> all outputs 0 next cycle. One subsequent edge produces no pulses; the second edge restarts them.
- Timer expiry forced onto the hall_rise cycle -> exactly one column_ready, with idx 0/0.
